// File: rtl/cpcs_dec_rd_multi.sv
// ----------------------------------------------------------------------------
// cpcs_dec_rd_multi
//
// Running-disparity (RD) checker for NSYM 8B10B code groups per byte-clock
// beat. It takes the per-symbol disparity classifications produced by the
// 6B/4B classifiers, chains RD through the symbols of a beat (symbol 0 first)
// and keeps RD in a register between beats. Each sub-block that is illegal
// for the RD it enters at is flagged.
//
// Optional feature, macro CPCS_DEC_RD_ERR_CNT_EN:
//   when defined, a saturating error counter (err_cnt) and a registered
//   threshold flag (err_thr) are built. When undefined, both are tied to 0.
//
// Parameters
//   NSYM     code groups per beat (1..8)
//   RD_INIT  RD after reset (0 = RD-, 1 = RD+)
//   CNT_W    error counter width
//   THRESH   err_thr asserts when err_cnt >= THRESH
//
// Ports
//   rbc1          receive byte clock, rising edge
//   reset_l       asynchronous active-low reset
//   in_valid      beat qualifier for all symbol flags
//   pd6bu/nd6bu   per symbol: 6B sub-block drives RD to + / to -
//   pd6bc/nd6bc   per symbol: 6B sub-block illegal when entered at RD- / RD+
//   pd4bu/nd4bu   per symbol: 4B sub-block drives RD to + / to -
//   pd4bc/nd4bc   per symbol: 4B sub-block illegal when entered at RD- / RD+
//   rd_load       force RD to rd_load_val (comma realignment)
//   rd_load_val   value loaded by rd_load
//   cnt_clr       synchronous clear of err_cnt / err_thr
//   out_valid     registered in_valid
//   derr6/derr4   per-symbol 6B / 4B disparity errors, registered
//   rd_err        OR of all derr6/derr4 bits of the beat
//   rd_out        current RD register
//   err_cnt       saturating error count
//   err_thr       err_cnt >= THRESH, registered
// ----------------------------------------------------------------------------
module cpcs_dec_rd_multi #(
   parameter int NSYM    = 2,
   parameter bit RD_INIT = 1'b0,
   parameter int CNT_W   = 8,
   parameter int THRESH  = 16
) (
   input  logic             rbc1,
   input  logic             reset_l,
   input  logic             in_valid,
   input  logic [NSYM-1:0]  pd6bu,
   input  logic [NSYM-1:0]  nd6bu,
   input  logic [NSYM-1:0]  pd6bc,
   input  logic [NSYM-1:0]  nd6bc,
   input  logic [NSYM-1:0]  pd4bu,
   input  logic [NSYM-1:0]  nd4bu,
   input  logic [NSYM-1:0]  pd4bc,
   input  logic [NSYM-1:0]  nd4bc,
   input  logic             rd_load,
   input  logic             rd_load_val,
   input  logic             cnt_clr,
   output logic             out_valid,
   output logic [NSYM-1:0]  derr6,
   output logic [NSYM-1:0]  derr4,
   output logic             rd_err,
   output logic             rd_out,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_thr
);

   logic [NSYM-1:0] derr6_c;
   logic [NSYM-1:0] derr4_c;
   logic            rd_chain;

   // RD chain across the beat. RD is propagated as if every sub-block were
   // legal, so an error flagged on one symbol never disturbs the RD seen by
   // the following symbols.
   always_comb begin
      logic r;
      logic rd6;
      // NOTE: blocking assignments are used here on purpose; r carries the
      // running value from one loop iteration to the next within the same
      // evaluation, which non-blocking assignments would not do.
      r       = rd_out;
      rd6     = 1'b0;
      derr6_c = '0;
      derr4_c = '0;
      for (int i = 0; i < NSYM; i++) begin
         derr6_c[i] = r ? nd6bc[i] : pd6bc[i];
         rd6        = (pd6bu[i] | r) & ~nd6bu[i];
         derr4_c[i] = rd6 ? nd4bc[i] : pd4bc[i];
         r          = (pd4bu[i] | rd6) & ~nd4bu[i];
      end
      rd_chain = r;
   end

   // NOTE: every register uses non-blocking assignment so that all of them
   // sample pre-edge values, independent of statement order.
   always_ff @(posedge rbc1 or negedge reset_l) begin
      if (!reset_l) begin
         rd_out    <= RD_INIT;
         out_valid <= 1'b0;
         derr6     <= '0;
         derr4     <= '0;
         rd_err    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            derr6  <= derr6_c;
            derr4  <= derr4_c;
            rd_err <= |(derr6_c | derr4_c);
         end else begin
            derr6  <= '0;
            derr4  <= '0;
            rd_err <= 1'b0;
         end
         // A load overrides the chain result; the errors of this beat were
         // already evaluated against the old RD above.
         if (rd_load) begin
            rd_out <= rd_load_val;
         end else if (in_valid) begin
            rd_out <= rd_chain;
         end
      end
   end

`ifdef CPCS_DEC_RD_ERR_CNT_EN
   // Four spare bits hold the largest count plus up to 8 new errors, so the
   // saturation test never sees a wrapped sum.
   localparam int SUM_W = CNT_W + 4;
   localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};
   localparam logic [SUM_W-1:0] THR_V   = SUM_W'(THRESH);

   logic [SUM_W-1:0] pop;
   logic [SUM_W-1:0] base;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_nxt;
   logic             thr_nxt;

   always_comb begin
      pop = '0;
      if (in_valid) begin
         for (int i = 0; i < NSYM; i++) begin
            // At most one error per symbol even if both sub-blocks fail.
            pop = pop + SUM_W'(derr6_c[i] | derr4_c[i]);
         end
      end
      base    = cnt_clr ? '0 : {4'b0000, err_cnt};
      sum     = base + pop;
      cnt_nxt = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      thr_nxt = ({4'b0000, cnt_nxt} >= THR_V);
   end

   always_ff @(posedge rbc1 or negedge reset_l) begin
      if (!reset_l) begin
         err_cnt <= '0;
         err_thr <= 1'b0;
      end else begin
         err_cnt <= cnt_nxt;
         err_thr <= thr_nxt;
      end
   end
`else
   localparam int unused_thresh = THRESH;
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign err_cnt        = '0;
   assign err_thr        = 1'b0;
`endif

endmodule
